matmul_seq: RTL and testbench
=============================

Name: matmul_seq

Overview:
- Sequencer for the 16x16 matrix-multiply datapath.
- On a start pulse it walks every (i, j, k) triple of C = A x B and issues paired operand reads from the 512-word operand memory. A is row-major at 0x000-0x0FF; B is row-major at 0x100-0x1FF and read down columns.
- Generates aligned MAC control (clear, enable, last) and result-buffer write strobes.
- Supports a stall input and a start/busy/done handshake.

Parameters:
ADDRLEN, 9, operand memory address width
RD_LAT, 1, operand memory read latency in cycles (1..4)
B_BASE, 256, base address of matrix B

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  begin multiply; sampled only in IDLE
hold  in  1  stall: no read issued, i/j/k frozen
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse at completion
rd_en  out  1  operand read strobe (both ports)
addr_a  out  ADDRLEN  A address = i*16 + k
addr_b  out  ADDRLEN  B address = B_BASE + k*16 + j
mac_en  out  1  operand data valid at MAC this cycle
mac_clr  out  1  with mac_en: first term (k=0), load instead of accumulate
mac_last  out  1  with mac_en: final term (k=15)
res_we  out  1  write finished C[i][j]
res_addr  out  8  result address = i*16 + j

Behaviour:
- Reset: state IDLE; i, j, k = 0; delay pipeline cleared. Every output is 0, including addr_a and addr_b.
- rst mid-operation: aborts immediately. No done pulse; all in-flight strobes are discarded.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start=1; start is ignored in every other state.
- RUN: each cycle with hold=0 drives rd_en=1 and addresses from the current i, j, k, then advances the counters.
  - k increments; at k=15 it wraps to 0 and j increments.
  - At j=15 and k=15, j wraps to 0 and i increments.
  - After the issue with i=j=k=15, the state becomes DRAIN and the counters return to 0.
- hold=1 in RUN: rd_en=0; addr_a and addr_b keep their values; counters frozen. The delay pipeline still advances, so a bubble enters.
- hold is ignored in IDLE, DRAIN and DONE.
- addr_a and addr_b are don't-care whenever rd_en=0, except at reset.
- MAC alignment: mac_en, mac_clr and mac_last equal rd_en, (rd_en and k==0) and (rd_en and k==15) delayed exactly RD_LAT cycles through a shift pipeline.
- Result write: res_we = mac_last delayed 1 cycle. res_addr carries the i*16+j of that last term through the same delay.
- Outputs are registered or combinational from registered state, with no combinational path from start or hold to any output.
- DRAIN: lasts until the final res_we has been driven, then the state becomes DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- A start arriving during DONE is ignored; start is accepted again from IDLE, i.e. the following cycle.
- Timing with no hold, start sampled at the edge ending cycle 0:
  - rd_en in cycles 1..4096
  - mac_en in cycles 1+RD_LAT .. 4096+RD_LAT
  - res_we at cycle 16m+RD_LAT+1 for m = 1..256
  - done at cycle 4098+RD_LAT
  - busy over cycles 1..4097+RD_LAT
- Each hold cycle in RUN adds exactly one cycle to every later event.
- Arithmetic: counters are 4 bits wide and wrap naturally. Addresses are built by concatenation; {i,k} and {k,j} are OR'd with B_BASE, with no carries.

Test Plan:
1. RD_LAT=1, single start, no hold:
   - cycle 1: addr_a=0x000, addr_b=0x100
   - cycle 2: addr_b=0x110
   - cycle 17: addr_a=0x000, addr_b=0x101
   - cycle 4096: addr_a=0x0FF, addr_b=0x1FF
   - res_we with res_addr=0 at cycle 18; res_addr=255 at cycle 4098
   - done pulse at cycle 4099; exactly 4096 rd_en and 256 res_we.
2. Model check: preload A, B with random 8-bit values and feed an ideal memory and MAC driven by mac_clr/mac_en. All 256 written results must equal reference C.
3. hold high for cycles 5-7 and 40: rd_en low on those cycles with addresses and counters frozen. Every later event shifts by 4 cycles (done at cycle 4103); results are unchanged.
4. RD_LAT=3: mac_en in cycles 4..4099; mac_clr on cycles 4, 20, ...; done at cycle 4101.
5. start pulsed during RUN and during DONE -> ignored, with no second run. start on the cycle after done -> new run whose first rd_en comes one cycle later.
6. rst asserted at cycle 2000 -> next cycle all outputs 0 and no done pulse. start afterwards -> full correct run from addr_a=0x000.

Source files
------------

// File: rtl/matmul_seq.sv
// matmul_seq -- address/control sequencer for the 16x16 matrix-multiply datapath.
//
// On a start pulse it walks every (i, j, k) triple of C = A x B. Each issue
// reads A[i][k] (row-major from address 0) and B[k][j] (row-major from
// B_BASE, walked down a column) from the operand memory. The MAC controls
// are delayed to line up with the read data, and a result-buffer write
// strobe follows the last term of every C element.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin a multiply (only looked at in IDLE)
//   hold            stall: no read issued next cycle, counters frozen
//   busy, done      busy in RUN/DRAIN, one-cycle done pulse at completion
//   rd_en           operand read strobe for both memory ports
//   addr_a, addr_b  operand addresses {i,k} and B_BASE | {k,j}
//   mac_en          operand data valid at the MAC this cycle
//   mac_clr         with mac_en: first term, load instead of accumulate
//   mac_last        with mac_en: final term of the dot product
//   res_we          write the finished C[i][j]
//   res_addr        result address {i,j}
//
// All outputs are registers or decode registered state only; start and hold
// are consumed at the clock edge, so a hold seen in cycle N suppresses the
// issue in cycle N+1.

module matmul_seq #(
    parameter int ADDRLEN = 9,
    parameter int RD_LAT  = 1,
    parameter int B_BASE  = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               hold,
    output logic               busy,
    output logic               done,
    output logic               rd_en,
    output logic [ADDRLEN-1:0] addr_a,
    output logic [ADDRLEN-1:0] addr_b,
    output logic               mac_en,
    output logic               mac_clr,
    output logic               mac_last,
    output logic               res_we,
    output logic [7:0]         res_addr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Pipeline word: {en, clr, last, i[3:0], j[3:0]}
    localparam int PW = 11;

    state_t             state_reg;
    logic [3:0]         i_reg;
    logic [3:0]         j_reg;
    logic [3:0]         k_reg;
    logic               rd_en_reg;
    logic [ADDRLEN-1:0] addr_a_reg;
    logic [ADDRLEN-1:0] addr_b_reg;
    logic               res_we_reg;
    logic [7:0]         res_addr_reg;

    logic               issue;
    logic               last_issue;
    logic [PW-1:0]      pipe_in;
    logic [PW-1:0]      pipe_reg [RD_LAT];

    // The first read is issued on the same edge that accepts start, so
    // rd_en rises in the first RUN cycle. In IDLE the counters are always 0.
    assign issue      = ((state_reg == IDLE) && start) ||
                        ((state_reg == RUN) && !hold);
    assign last_issue = (i_reg == 4'hF) && (j_reg == 4'hF) && (k_reg == 4'hF);

    // Sequencer: state, counters and the registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            i_reg      <= 4'h0;
            j_reg      <= 4'h0;
            k_reg      <= 4'h0;
            rd_en_reg  <= 1'b0;
            addr_a_reg <= '0;
            addr_b_reg <= '0;
        end else begin
            rd_en_reg <= issue;
            if (issue) begin
                // B_BASE has no bits in the low byte, so OR is the add.
                addr_a_reg <= ADDRLEN'({i_reg, k_reg});
                addr_b_reg <= ADDRLEN'(B_BASE) | ADDRLEN'({k_reg, j_reg});
                // 4-bit counters wrap naturally; after the final issue all
                // three are back at 0, ready for the next run.
                k_reg <= k_reg + 4'h1;
                if (k_reg == 4'hF) begin
                    j_reg <= j_reg + 4'h1;
                    if (j_reg == 4'hF) begin
                        i_reg <= i_reg + 4'h1;
                    end
                end
            end
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (!hold && last_issue) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The write of C[15][15] is the last event of a run.
                    if (res_we_reg && (res_addr_reg == 8'hFF)) begin
                        state_reg <= DONE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // k lives in addr_a[3:0], i in addr_a[7:4] and j in addr_b[3:0], so the
    // flags and result index can be taken from the issued addresses.
    assign pipe_in = {rd_en_reg,
                      rd_en_reg && (addr_a_reg[3:0] == 4'h0),
                      rd_en_reg && (addr_a_reg[3:0] == 4'hF),
                      addr_a_reg[7:4],
                      addr_b_reg[3:0]};

    // RD_LAT-deep delay line; it keeps shifting during hold so bubbles
    // travel with the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < RD_LAT; s++) begin
                pipe_reg[s] <= '0;
            end
        end else begin
            pipe_reg[0] <= pipe_in;
            for (int s = 1; s < RD_LAT; s++) begin
                pipe_reg[s] <= pipe_reg[s-1];
            end
        end
    end

    // The result write trails the last MAC term by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_we_reg   <= 1'b0;
            res_addr_reg <= 8'h00;
        end else begin
            res_we_reg <= pipe_reg[RD_LAT-1][PW-3];
            if (pipe_reg[RD_LAT-1][PW-3]) begin
                res_addr_reg <= pipe_reg[RD_LAT-1][7:0];
            end
        end
    end

    assign busy     = (state_reg == RUN) || (state_reg == DRAIN);
    assign done     = (state_reg == DONE);
    assign rd_en    = rd_en_reg;
    assign addr_a   = addr_a_reg;
    assign addr_b   = addr_b_reg;
    assign mac_en   = pipe_reg[RD_LAT-1][PW-1];
    assign mac_clr  = pipe_reg[RD_LAT-1][PW-2];
    assign mac_last = pipe_reg[RD_LAT-1][PW-3];
    assign res_we   = res_we_reg;
    assign res_addr = res_addr_reg;

endmodule

// File: tb/tb_matmul_seq.sv
// tb_matmul_seq -- self-checking bench for matmul_seq.
//
// Two sequencers (read latency 1 and 3) run side by side on shared clk, rst
// and hold, each with its own start. Each instance has an ideal operand
// memory and MAC driven by its strobes; reference C values are queued when a
// run is started and popped on every res_we. Directed checks cover the
// address walk, hold bubbles, start being ignored outside IDLE, restart
// right after done, and a mid-run reset.

`timescale 1ns/1ps

module tb_matmul_seq;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      start_v;
    logic            hold;
    logic [1:0]      busy_w, done_w, rd_en_w, mac_en_w, mac_clr_w, mac_last_w, res_we_w;
    logic [1:0][8:0] addr_a_w, addr_b_w;
    logic [1:0][7:0] res_addr_w;

    int          cyc = 0;
    int          n_chk;
    int          n_fail;
    int          t0 [2];
    int          exp_done [2];
    int          exp_first_we [2];
    int          runs_done [2];
    bit          armed [2];
    logic [31:0] sb_q [2][$];    // {res_addr, value[23:0]}
    logic [7:0]  mem_a [256];
    logic [7:0]  mem_b [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic longint outs_of(input int g);
        return {busy_w[g], done_w[g], rd_en_w[g], addr_a_w[g], addr_b_w[g],
                mac_en_w[g], mac_clr_w[g], mac_last_w[g], res_we_w[g], res_addr_w[g]};
    endfunction

    // Start-of-run bookkeeping: timing expectations and the reference C.
    // nh hold cycles: three of them precede the first result write.
    task automatic arm(input int g, input int nh);
        int c;
        t0[g]           = cyc;
        exp_done[g]     = 4098 + lat_of(g) + nh;
        exp_first_we[g] = 17 + lat_of(g) + ((nh > 0) ? 3 : 0);
        armed[g]        = 1'b1;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                c = 0;
                for (int k = 0; k < 16; k++) begin
                    c += int'(mem_a[i*16+k]) * int'(mem_b[k*16+j]);
                end
                sb_q[g].push_back({8'(i*16+j), 24'(c)});
            end
        end
    endtask

    task automatic chk_addr(input int g, input string tag, input logic [8:0] ea, input logic [8:0] eb);
        check({tag, "_rd_en"}, rd_en_w[g], 1);
        check({tag, "_addr_a"}, addr_a_w[g], ea);
        check({tag, "_addr_b"}, addr_b_w[g], eb);
    endtask

    task automatic fill_mem();
        for (int n = 0; n < 256; n++) begin
            mem_a[n] = 8'($urandom_range(0, 255));
            mem_b[n] = 8'($urandom_range(0, 255));
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int L = (gi == 0) ? 1 : 3;

        logic [17:0] fifo_q [$];   // issued {addr_a, addr_b} awaiting mac_en
        int acc, n_rd, n_mac, n_we, first_rd, first_mac, first_we;

        matmul_seq #(
            .ADDRLEN(9),
            .RD_LAT (L),
            .B_BASE (256)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .start   (start_v[gi]),
            .hold    (hold),
            .busy    (busy_w[gi]),
            .done    (done_w[gi]),
            .rd_en   (rd_en_w[gi]),
            .addr_a  (addr_a_w[gi]),
            .addr_b  (addr_b_w[gi]),
            .mac_en  (mac_en_w[gi]),
            .mac_clr (mac_clr_w[gi]),
            .mac_last(mac_last_w[gi]),
            .res_we  (res_we_w[gi]),
            .res_addr(res_addr_w[gi])
        );

        always @(negedge clk) begin : mon
            int          rel;
            int          prod;
            logic [17:0] ent;
            logic [31:0] e;
            rel = cyc - t0[gi];
            if (rst) begin
                fifo_q.delete();
                acc = 0; n_rd = 0; n_mac = 0; n_we = 0;
            end else begin
                // Result write sees the accumulator before this cycle's term.
                if (res_we_w[gi]) begin
                    n_we++;
                    if (n_we == 1) first_we = rel;
                    if (sb_q[gi].size() == 0) begin
                        check("sb_size", sb_q[gi].size(), 1);
                    end else begin
                        e = sb_q[gi].pop_front();
                        check("res_addr", res_addr_w[gi], e[31:24]);
                        check("res_val", acc, e[23:0]);
                    end
                end
                if (mac_en_w[gi]) begin
                    n_mac++;
                    if (n_mac == 1) first_mac = rel;
                    if (fifo_q.size() == 0) begin
                        check("mac_fifo_size", fifo_q.size(), 1);
                    end else begin
                        ent = fifo_q.pop_front();
                        check("addr_form", {ent[17], ent[8], ent[7:4]}, {1'b0, 1'b1, ent[12:9]});
                        check("mac_clr", mac_clr_w[gi], ent[12:9] == 4'h0);
                        check("mac_last", mac_last_w[gi], ent[12:9] == 4'hF);
                        prod = int'(mem_a[ent[16:9]]) * int'(mem_b[ent[7:0]]);
                        acc  = mac_clr_w[gi] ? prod : acc + prod;
                    end
                end else if (mac_clr_w[gi] || mac_last_w[gi]) begin
                    check("stray_clr_last", {mac_clr_w[gi], mac_last_w[gi]}, 0);
                end
                if (rd_en_w[gi]) begin
                    n_rd++;
                    if (n_rd == 1) first_rd = rel;
                    fifo_q.push_back({addr_a_w[gi], addr_b_w[gi]});
                end
                if (armed[gi] && (rel == 1 || rel == exp_done[gi] - 1)) begin
                    check("busy_run", busy_w[gi], 1);
                end
                if (done_w[gi]) begin
                    if (!armed[gi]) begin
                        check("unexpected_done", done_w[gi], 0);
                    end else begin
                        check("done_cycle", rel, exp_done[gi]);
                        check("busy_at_done", busy_w[gi], 0);
                        check("rd_count", n_rd, 4096);
                        check("mac_count", n_mac, 4096);
                        check("we_count", n_we, 256);
                        check("first_rd", first_rd, 1);
                        check("first_mac", first_mac, 1 + L);
                        check("first_we", first_we, exp_first_we[gi]);
                        check("sb_left", sb_q[gi].size(), 0);
                        $display("run dut%0d rd_lat=%0d done_cycle=%0d rd=%0d mac=%0d we=%0d",
                                 gi, L, rel, n_rd, n_mac, n_we);
                        armed[gi] = 1'b0;
                        runs_done[gi]++;
                    end
                    fifo_q.delete();
                    n_rd = 0; n_mac = 0; n_we = 0;
                end
            end
        end
    end

    // One run from the current posedge+1 (cycle 0). Optional hold bubbles,
    // restart right after done, or a reset at cycle rst_at.
    task automatic do_run(input bit with_hold, input bit restart, input int rst_at);
        int         r;
        int         target [2];
        int         d0 [2];
        logic [8:0] prev_a [2];
        logic [8:0] prev_b [2];
        @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            arm(g, with_hold ? 4 : 0);
            d0[g]     = exp_done[g];
            target[g] = runs_done[g] + (restart ? 2 : 1);
            prev_a[g] = '0;
            prev_b[g] = '0;
        end
        start_v = 2'b11;
        r = 0;
        while (r < 9000) begin
            @(posedge clk);
            #1;
            r++;
            start_v = 2'b00;
            // hold seen in cycle r removes the issue of cycle r+1.
            hold = with_hold && (r == 4 || r == 5 || r == 6 || r == 39);
            if (r == 100 || r == 4097) start_v = 2'b11;
            if (restart) begin
                for (int g = 0; g < 2; g++) begin
                    if (r == d0[g]) start_v[g] = 1'b1;
                    if (r == d0[g] + 1) begin
                        start_v[g] = 1'b1;
                        arm(g, 0);
                    end
                end
            end
            if (r == rst_at) begin
                rst = 1'b1;
                for (int g = 0; g < 2; g++) begin
                    armed[g] = 1'b0;
                    sb_q[g].delete();
                end
            end
            if (r == rst_at + 1) rst = 1'b0;
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (!with_hold) begin
                    if (r == 1)    chk_addr(g, "c1", 9'h000, 9'h100);
                    if (r == 2)    chk_addr(g, "c2", 9'h001, 9'h110);
                    if (r == 17)   chk_addr(g, "c17", 9'h000, 9'h101);
                    if (r == 4096) chk_addr(g, "c4096", 9'h0FF, 9'h1FF);
                end else begin
                    if (r == 5 || r == 6 || r == 7 || r == 40) begin
                        check("hold_rd_en", rd_en_w[g], 0);
                        check("hold_addr_a", addr_a_w[g], prev_a[g]);
                        check("hold_addr_b", addr_b_w[g], prev_b[g]);
                    end
                    if (r == 8)  chk_addr(g, "after_hold8", 9'h004, 9'h140);
                    if (r == 41) chk_addr(g, "after_hold41", 9'h004, 9'h142);
                end
                if (rst_at > 0 && r == rst_at + 1)   check("abort_outs", outs_of(g), 0);
                if (rst_at > 0 && r == rst_at + 100) check("abort_busy", busy_w[g], 0);
                prev_a[g] = addr_a_w[g];
                prev_b[g] = addr_b_w[g];
            end
            if (rst_at > 0) begin
                if (r >= rst_at + 120) break;
            end else if (runs_done[0] >= target[0] && runs_done[1] >= target[1]) begin
                break;
            end
        end
        if (rst_at == 0) begin
            check("runs_completed", runs_done[0] + runs_done[1], target[0] + target[1]);
        end
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        rst     = 1'b1;
        start_v = 2'b00;
        hold    = 1'b0;
        for (int g = 0; g < 2; g++) begin
            t0[g]        = 0;
            exp_done[g]  = 0;
            runs_done[g] = 0;
            armed[g]     = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) check("reset_outs", outs_of(g), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        fill_mem();
        do_run(1'b0, 1'b1, 0);     // plain run, stray starts, restart after done
        fill_mem();
        do_run(1'b1, 1'b0, 0);     // hold bubbles at cycles 5-7 and 40
        fill_mem();
        do_run(1'b0, 1'b0, 2000);  // reset in the middle of a run
        fill_mem();
        do_run(1'b0, 1'b0, 0);     // clean run after the abort

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
